// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the half-precision multiplier datapath.
package mult_pkg;

  localparam int unsigned MAN_W    = 10;
  localparam int unsigned SIG_W    = MAN_W + 1;
  localparam int unsigned EXP_BIAS = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mant_round.sv
// Combinational round-to-nearest-even on a normalized fraction.
// Used by mant_mult_seq only when MANT_ROUND_EN is defined.
module mant_round #(
  parameter int unsigned MAN_W = 10
) (
  input  logic [MAN_W-1:0] man,
  input  logic             guard,
  input  logic             sticky,
  input  logic             inc,
  output logic [MAN_W-1:0] man_c,
  output logic             inc_c
);

  logic           round_up;
  logic [MAN_W:0] sum;

  // A carry out of the fraction means the significand reached 2.0.
  always_comb begin
    round_up = guard & (sticky | man[0]);
    sum      = {1'b0, man} + (MAN_W + 1)'(round_up);
    man_c    = sum[MAN_W-1:0];
    inc_c    = inc | sum[MAN_W];
  end

endmodule

// File: rtl/mant_mult_seq.sv
// Sequential shift-add significand multiplier with normalization.
// Optional round-to-nearest-even in NORM when MANT_ROUND_EN is defined.
module mant_mult_seq #(
  parameter  int unsigned MAN_W = 10,
  localparam int unsigned SIG_W = MAN_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIG_W-1:0] sigA,
  input  logic [SIG_W-1:0] sigB,
  output logic             busy,
  output logic             done,
  output logic [MAN_W-1:0] man,
  output logic             inc,
  output logic             guard,
  output logic             sticky
);
  import mult_pkg::*;

  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned CNT_W  = $clog2(SIG_W + 1);

  state_t              state;
  logic [SIG_W-1:0]    mcand;
  logic [SIG_W-1:0]    mplier;
  logic [PROD_W-1:0]   acc;
  logic [CNT_W-1:0]    cnt;

  logic [SIG_W:0]      partial;
  logic                norm_inc;
  logic [MAN_W-1:0]    norm_man;
  logic                norm_guard;
  logic                norm_sticky;
  logic [MAN_W-1:0]    final_man;
  logic                final_inc;

  // One shift-add step: conditionally add the multiplicand into the upper half.
  always_comb begin
    partial = {1'b0, acc[PROD_W-1:SIG_W]};
    if (mplier[0]) begin
      partial = partial + {1'b0, mcand};
    end
  end

  // Normalize so the leading one becomes the hidden bit.
  always_comb begin
    norm_inc = acc[PROD_W-1];
    if (norm_inc) begin
      norm_man    = acc[PROD_W-2 -: MAN_W];
      norm_guard  = acc[PROD_W-2-MAN_W];
      norm_sticky = |acc[PROD_W-3-MAN_W:0];
    end else begin
      norm_man    = acc[PROD_W-3 -: MAN_W];
      norm_guard  = acc[PROD_W-3-MAN_W];
      norm_sticky = |acc[PROD_W-4-MAN_W:0];
    end
  end

`ifdef MANT_ROUND_EN
  mant_round #(
    .MAN_W (MAN_W)
  ) u_round (
    .man    (norm_man),
    .guard  (norm_guard),
    .sticky (norm_sticky),
    .inc    (norm_inc),
    .man_c  (final_man),
    .inc_c  (final_inc)
  );
`else
  assign final_man = norm_man;
  assign final_inc = norm_inc;
`endif

  // Control FSM and datapath registers; outputs held from DONE until the next NORM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      man    <= '0;
      inc    <= 1'b0;
      guard  <= 1'b0;
      sticky <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= sigA;
            mplier <= sigB;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= MUL;
          end else begin
            state  <= IDLE;
          end
        end
        MUL: begin
          acc    <= {partial, acc[SIG_W-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(SIG_W - 1)) begin
            state <= NORM;
          end
        end
        NORM: begin
          man    <= final_man;
          inc    <= final_inc;
          guard  <= norm_guard;
          sticky <= norm_sticky;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mant_mult_seq.sv
// Scoreboard bench for mant_mult_seq: randomized and directed operands against
// an arithmetic reference model; honours MANT_ROUND_EN like the design.
module tb_mant_mult_seq;

  localparam int unsigned MAN_W   = 10;
  localparam int unsigned SIG_W   = MAN_W + 1;
  localparam int          LATENCY = SIG_W + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [SIG_W-1:0] sig_a = '0;
  logic [SIG_W-1:0] sig_b = '0;
  logic             busy;
  logic             done;
  logic [MAN_W-1:0] man;
  logic             inc;
  logic             guard;
  logic             sticky;

  typedef struct {
    logic [MAN_W-1:0] man;
    logic             inc;
    logic             guard;
    logic             sticky;
    int               acc_cyc;
    logic [SIG_W-1:0] a;
    logic [SIG_W-1:0] b;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  mant_mult_seq #(.MAN_W(MAN_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sigA   (sig_a),
    .sigB   (sig_b),
    .busy   (busy),
    .done   (done),
    .man    (man),
    .inc    (inc),
    .guard  (guard),
    .sticky (sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer product, then normalize/round by value.
  function automatic exp_t model(input logic [SIG_W-1:0] a, input logic [SIG_W-1:0] b,
                                 input int acc_cyc);
    exp_t        e;
    int unsigned p;
    int unsigned m;
    p = 32'(a) * 32'(b);
    e.inc = 1'(p >= 32'h0020_0000);
    if (e.inc) begin
      m        = (p >> 11) % 1024;
      e.guard  = 1'((p >> 10) % 2);
      e.sticky = 1'((p % 1024) != 0);
    end else begin
      m        = (p >> 10) % 1024;
      e.guard  = 1'((p >> 9) % 2);
      e.sticky = 1'((p % 512) != 0);
    end
`ifdef MANT_ROUND_EN
    if (e.guard && (e.sticky || (m % 2 == 1))) m = m + 1;
    if (m == 1024) begin
      m     = 0;
      e.inc = 1'b1;
    end
`endif
    e.man     = MAN_W'(m);
    e.acc_cyc = acc_cyc;
    e.a       = a;
    e.b       = b;
    return e;
  endfunction

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done <= 1'b0;
    end else begin
      if (done && prev_done) check("done_single_pulse", 1, 0);
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("man", int'(man), int'(e.man));
          check("inc", int'(inc), int'(e.inc));
          check("guard", int'(guard), int'(e.guard));
          check("sticky", int'(sticky), int'(e.sticky));
          check("latency", cyc - e.acc_cyc, LATENCY);
          check("busy_in_done", int'(busy), 0);
        end
      end
      prev_done <= done;
    end
  end

  // Drive one request at the first negedge with busy low; inputs scrambled afterwards.
  task automatic issue(input logic [SIG_W-1:0] a, input logic [SIG_W-1:0] b);
    int t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("issue_timeout", 1, 0);
    start = 1'b1;
    sig_a = a;
    sig_b = b;
    q.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    sig_a = SIG_W'($urandom);
    sig_b = SIG_W'($urandom);
    check("accepted_busy", int'(busy), 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 1, 0);
      q.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_man"}, int'(man), 0);
    check({tag, "_inc"}, int'(inc), 0);
    check({tag, "_guard"}, int'(guard), 0);
    check({tag, "_sticky"}, int'(sticky), 0);
  endtask

  function automatic logic [SIG_W-1:0] rand_sig();
    if ($urandom_range(0, 15) == 0) return '0;
    return SIG_W'($urandom) | SIG_W'(1 << (SIG_W - 1));
  endfunction

  initial begin
    logic [SIG_W-1:0] a;
    logic [SIG_W-1:0] b;

    repeat (2) @(negedge clk);
    #1 check_zero_outputs("reset");
    rst_n = 1'b1;

    // Directed corner values.
    issue(11'h400, 11'h400); wait_idle();
    issue(11'h600, 11'h600); wait_idle();
    issue(11'h7FF, 11'h7FF); wait_idle();
    issue(11'h5A8, 11'h5A8); wait_idle();
    issue(11'h000, 11'h7FF); wait_idle();

    // Stray start mid-operation must be ignored.
    issue(11'h4D3, 11'h6AB);
    repeat (3) @(negedge clk);
    start = 1'b1;
    sig_a = 11'h7FF;
    sig_b = 11'h7FF;
    check("stray_start_busy", int'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("no_extra_result", q.size(), 0);

    // Back-to-back: second request lands in the DONE cycle.
    issue(11'h5A8, 11'h5A8);
    issue(11'h7FF, 11'h401);
    wait_idle();

    // Asynchronous reset mid-operation aborts without a result.
    issue(11'h7FF, 11'h7FF); wait_idle();
    issue(11'h6F1, 11'h733);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("abort");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", q.size(), 0);
    issue(11'h600, 11'h600); wait_idle();

    // Randomized traffic with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      a = rand_sig();
      b = rand_sig();
      issue(a, b);
      if ($urandom_range(0, 2) == 0) wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
